mem_bus_slave: RTL and testbench

//  Main-bus slave controller in front of the memory array. Decodes address cycles on the

---
 rtl/mem_bus_slave_pkg.sv | 22 ++
 rtl/mem_bus_slave_if.sv | 33 +++
 rtl/mem_bus_slave.sv | 97 +++++++++
 tb/tb_mem_bus_slave.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_slave_pkg.sv
// Shared constants and types for the main-bus memory slave.
// Bus/word widths, burst length, page numbers and the FSM state type.
package mcDefs;

    localparam int BUS_W = 16;
    localparam int OFS_W = 12;
    localparam int BURST = 4;
    localparam int CNT_W = $clog2(BURST);

    localparam logic [3:0] MEMPAGE0 = 4'h0;
    localparam logic [3:0] MEMPAGE1 = 4'h1;
    localparam logic [3:0] MEMPAGE2 = 4'h2;
    localparam logic [3:0] MEMPAGE3 = 4'h3;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_PRE,
        RD
    } mbs_state_t;

endpackage

// File: rtl/mem_bus_slave_if.sv
// Multiplexed address/data main bus between a master and the memory slave.
// The master drives address cycles and write data; the slave drives read data.
interface mem_bus_slave_if #(
    parameter int BUS_W = 16
);
    logic             AddrValid;
    logic             rw;
    logic [BUS_W-1:0] AddrData_in;
    logic [BUS_W-1:0] AddrData_out;
    logic             AddrData_oe;
    logic             busy;
    logic             err;

    modport master (
        output AddrValid,
        output rw,
        output AddrData_in,
        input  AddrData_out,
        input  AddrData_oe,
        input  busy,
        input  err
    );

    modport slave (
        input  AddrValid,
        input  rw,
        input  AddrData_in,
        output AddrData_out,
        output AddrData_oe,
        output busy,
        output err
    );
endinterface

// File: rtl/mem_bus_slave.sv
// Main-bus slave: claims address cycles for one page and runs fixed-length
// write/read bursts against a synchronous single-port memory.
module mem_bus_slave #(
    parameter logic [3:0] PAGE  = mcDefs::MEMPAGE2,
    parameter int         BUS_W = mcDefs::BUS_W,
    parameter int         OFS_W = mcDefs::OFS_W,
    parameter int         BURST = mcDefs::BURST
) (
    input  logic             clk,
    input  logic             resetL,
    mem_bus_slave_if.slave   bus,
    output logic [OFS_W-1:0] mem_addr,
    output logic [BUS_W-1:0] mem_wdata,
    output logic             mem_we,
    output logic             mem_re,
    input  logic [BUS_W-1:0] mem_rdata
);
    import mcDefs::*;

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    mbs_state_t       state_q;
    logic [CW-1:0]    cnt_q;
    logic [OFS_W-1:0] base_q;

    logic claim;
    logic last;

    assign claim = bus.AddrValid
                && (bus.AddrData_in[BUS_W-1 -: 4] == PAGE);
    assign last  = (cnt_q == CW'(BURST - 1));

    always_ff @(posedge clk or negedge resetL) begin
        if (!resetL) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (claim) begin
                        base_q  <= bus.AddrData_in[OFS_W-1:0];
                        cnt_q   <= '0;
                        state_q <= bus.rw ? RD_PRE : WR;
                    end
                end
                RD_PRE: begin
                    cnt_q   <= '0;
                    state_q <= RD;
                end
                WR, RD: begin
                    if (last) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Offsets wrap inside the page by natural OFS_W-bit overflow.
    always_comb begin
        bus.AddrData_out = '0;
        bus.AddrData_oe  = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        mem_we           = 1'b0;
        mem_re           = 1'b0;
        unique case (state_q)
            WR: begin
                mem_we    = 1'b1;
                mem_addr  = base_q + OFS_W'(cnt_q);
                mem_wdata = bus.AddrData_in;
            end
            RD_PRE: begin
                mem_re   = 1'b1;
                mem_addr = base_q;
            end
            RD: begin
                bus.AddrData_oe  = 1'b1;
                bus.AddrData_out = mem_rdata;
                if (!last) begin
                    mem_re   = 1'b1;
                    mem_addr = base_q + OFS_W'(cnt_q) + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.err  = bus.busy && bus.AddrValid;

endmodule

// File: tb/tb_mem_bus_slave.sv
// Directed bench for mem_bus_slave with a behavioural synchronous memory.
// Inputs change 1 ns after posedge; outputs are checked on negedge.
module tb_mem_bus_slave;

    logic        clk = 1'b0;
    logic        resetL;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;

    logic [15:0] mem [4096];

    int nchk = 0;
    int nerr = 0;

    logic [15:0] da [4];
    logic [15:0] dw [4];
    logic [15:0] de [4];
    logic [15:0] dr [4];

    mem_bus_slave_if bus ();

    mem_bus_slave dut (
        .clk       (clk),
        .resetL    (resetL),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.AddrValid   = 1'b0;
        bus.rw          = 1'b0;
        bus.AddrData_in = '0;
    endtask

    task automatic wr_burst(input logic [15:0] a,
                            input logic [15:0] d [4],
                            input int err_at);
        logic [11:0] ea;
        @(posedge clk); #1;
        bus.AddrValid   = 1'b1;
        bus.rw          = 1'b0;
        bus.AddrData_in = a;
        @(negedge clk);
        chk("wr_acyc_busy", 32'(bus.busy), 0);
        chk("wr_acyc_we", 32'(mem_we), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.AddrValid   = (i == err_at);
            bus.AddrData_in = d[i];
            @(negedge clk);
            ea = a[11:0] + 12'(i);
            chk("wr_busy", 32'(bus.busy), 1);
            chk("wr_we", 32'(mem_we), 1);
            chk("wr_addr", 32'(mem_addr), 32'(ea));
            chk("wr_data", 32'(mem_wdata), 32'(d[i]));
            chk("wr_oe", 32'(bus.AddrData_oe), 0);
            chk("wr_err", 32'(bus.err), (i == err_at) ? 1 : 0);
        end
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        chk("wr_end_busy", 32'(bus.busy), 0);
        chk("wr_end_we", 32'(mem_we), 0);
    endtask

    task automatic rd_burst(input logic [15:0] a,
                            input logic [15:0] e [4]);
        logic [11:0] ea;
        @(posedge clk); #1;
        bus.AddrValid   = 1'b1;
        bus.rw          = 1'b1;
        bus.AddrData_in = a;
        @(negedge clk);
        chk("rd_acyc_busy", 32'(bus.busy), 0);
        @(posedge clk); #1;
        bus_idle();
        @(negedge clk);
        chk("rd_pre_busy", 32'(bus.busy), 1);
        chk("rd_pre_oe", 32'(bus.AddrData_oe), 0);
        chk("rd_pre_re", 32'(mem_re), 1);
        chk("rd_pre_addr", 32'(mem_addr), 32'(a[11:0]));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            ea = a[11:0] + 12'(i + 1);
            chk("rd_oe", 32'(bus.AddrData_oe), 1);
            chk("rd_data", 32'(bus.AddrData_out), 32'(e[i]));
            chk("rd_re", 32'(mem_re), (i < 3) ? 1 : 0);
            if (i < 3) chk("rd_addr", 32'(mem_addr), 32'(ea));
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_end_oe", 32'(bus.AddrData_oe), 0);
        chk("rd_end_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem_rdata = '0;
        da = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        dw = '{16'hA5A5, 16'h5A5A, 16'hBEEF, 16'hCAFE};
        de = '{16'h0101, 16'h0202, 16'h2040, 16'h0404};
        dr = '{16'h7001, 16'h7002, 16'h7003, 16'h7004};
        bus_idle();
        resetL = 1'b0;
        #12;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_oe", 32'(bus.AddrData_oe), 0);
        chk("rst_out", 32'(bus.AddrData_out), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_re", 32'(mem_re), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        @(negedge clk);
        resetL = 1'b1;

        // 1/2: plain write then read-back
        wr_burst(16'h2010, da, -1);
        for (int i = 0; i < 4; i++)
            chk("mem_t1", 32'(mem[12'h010 + i]), 32'(da[i]));
        rd_burst(16'h2010, da);

        // 3: offset wrap inside the page
        wr_burst(16'h2FFE, dw, -1);
        chk("mem_wrap_ffe", 32'(mem[12'hFFE]), 32'h0000A5A5);
        chk("mem_wrap_fff", 32'(mem[12'hFFF]), 32'h00005A5A);
        chk("mem_wrap_000", 32'(mem[12'h000]), 32'h0000BEEF);
        chk("mem_wrap_001", 32'(mem[12'h001]), 32'h0000CAFE);
        rd_burst(16'h2FFE, dw);

        // 4: other page is not claimed
        @(posedge clk); #1;
        bus.AddrValid   = 1'b1;
        bus.rw          = 1'b0;
        bus.AddrData_in = 16'h3010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("miss_busy", 32'(bus.busy), 0);
            chk("miss_oe", 32'(bus.AddrData_oe), 0);
            chk("miss_we", 32'(mem_we), 0);
            chk("miss_re", 32'(mem_re), 0);
            @(posedge clk); #1;
            bus.AddrValid   = 1'b0;
            bus.AddrData_in = 16'hDEAD;
        end
        bus_idle();
        chk("miss_mem", 32'(mem[12'h010]), 32'h00001111);

        // 5: address cycle in mid-burst flags err only
        wr_burst(16'h2030, de, 2);
        for (int i = 0; i < 4; i++)
            chk("mem_err", 32'(mem[12'h030 + i]), 32'(de[i]));
        chk("err_no_claim", 32'(mem[12'h040]), 0);

        // 6: async reset in the middle of a read
        @(posedge clk); #1;
        bus.AddrValid   = 1'b1;
        bus.rw          = 1'b1;
        bus.AddrData_in = 16'h2010;
        @(posedge clk); #1;
        bus_idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_oe", 32'(bus.AddrData_oe), 1);
        chk("mid_data", 32'(bus.AddrData_out), 32'h00002222);
        #2 resetL = 1'b0;
        #1;
        chk("arst_oe", 32'(bus.AddrData_oe), 0);
        chk("arst_re", 32'(mem_re), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_addr", 32'(mem_addr), 0);
        @(negedge clk);
        resetL = 1'b1;
        wr_burst(16'h2020, dr, -1);
        for (int i = 0; i < 4; i++)
            chk("mem_post_rst", 32'(mem[12'h020 + i]), 32'(dr[i]));
        rd_burst(16'h2020, dr);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
